// File: rtl/avalon_rr_arbiter_if.sv
// Avalon-MM bus bundle for N agents sharing one readdata return path.
// The master modport drives the request side; the slave modport answers with waitrequest/readdata.
interface avalon_rr_arbiter_if #(
   parameter int N  = 1,
   parameter int AW = 8,
   parameter int DW = 32
);
   logic [N*AW-1:0] address;
   logic [N*DW-1:0] writedata;
   logic [N-1:0]    read;
   logic [N-1:0]    write;
   logic [N-1:0]    waitrequest;
   logic [DW-1:0]   readdata;

   modport master (
      output address, writedata, read, write,
      input  waitrequest, readdata
   );

   modport slave (
      input  address, writedata, read, write,
      output waitrequest, readdata
   );
endinterface

// File: rtl/avalon_rr_arbiter.sv
// Round-robin share of one Avalon-MM slave among N_MASTERS masters, one transfer per grant.
// Latency: 1 idle/arbitration cycle, then slave wait cycles plus the completing edge.
module avalon_rr_arbiter #(
   parameter int N_MASTERS = 2,
   parameter int AW        = 8,
   parameter int DW        = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   avalon_rr_arbiter_if.slave   m,
   avalon_rr_arbiter_if.master  s,
   output logic [N_MASTERS-1:0] grant
);
   localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                state;
   logic [IW-1:0]         g_idx;
   logic [IW-1:0]         last;
   logic [N_MASTERS-1:0]  req;
   logic                  pick_vld;
   logic [IW-1:0]         pick_idx;
   logic                  done;

   assign req = m.read | m.write;

   // Search from last+1 upward; the descending loop lets the nearest requester win.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int k = N_MASTERS; k >= 1; k--) begin
         int idx;
         idx = (int'(last) + k) % N_MASTERS;
         if (req[idx]) begin
            pick_vld = 1'b1;
            pick_idx = IW'(idx);
         end
      end
   end

   always_comb begin
      s.address      = '0;
      s.writedata    = '0;
      s.read         = 1'b0;
      s.write        = 1'b0;
      m.waitrequest  = '1;
      m.readdata     = s.readdata;
      if (state == BUSY) begin
         s.address               = m.address[int'(g_idx)*AW +: AW];
         s.writedata             = m.writedata[int'(g_idx)*DW +: DW];
         s.write                 = m.write[g_idx];
         s.read                  = m.read[g_idx] & ~m.write[g_idx];
         m.waitrequest[g_idx]    = s.waitrequest[0];
      end
   end

   assign done = (s.read[0] | s.write[0]) & ~s.waitrequest[0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         grant <= '0;
         g_idx <= '0;
         last  <= IW'(N_MASTERS - 1);
      end else begin
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  state <= BUSY;
                  g_idx <= pick_idx;
                  grant <= N_MASTERS'(1) << pick_idx;
               end
            end
            BUSY: begin
               // Completion and abandon both hand priority away from the owner.
               if (done || !req[g_idx]) begin
                  state <= IDLE;
                  grant <= '0;
                  last  <= g_idx;
               end
            end
            default: begin
               state <= IDLE;
               grant <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_avalon_rr_arbiter.sv
// Directed bench for avalon_rr_arbiter with two masters and a slave that releases waitrequest
// one cycle after a strobe appears.
module tb_avalon_rr_arbiter;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:0] grant;
   logic       force_wait = 1'b0;
   logic       slv_hold;
   int         errors = 0;
   int         checks = 0;

   avalon_rr_arbiter_if #(.N(2), .AW(8), .DW(32)) m_if ();
   avalon_rr_arbiter_if #(.N(1), .AW(8), .DW(32)) s_if ();

   avalon_rr_arbiter #(.N_MASTERS(2), .AW(8), .DW(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .m       (m_if),
      .s       (s_if),
      .grant   (grant)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) slv_hold <= 1'b0;
      else          slv_hold <= (s_if.read[0] | s_if.write[0]) & ~slv_hold;
   end
   assign s_if.waitrequest = force_wait | ~slv_hold;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [1:0] rd);
      reset_n = 1'b0;
      m_if.read = rd;
      m_if.write = 2'b00;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      m_if.address   = {8'h3C, 8'h10};
      m_if.writedata = {32'hDEADBEEF, 32'h11111111};
      s_if.readdata  = 32'h0;
      reset_n = 1'b0;
      m_if.read = 2'b11;
      m_if.write = 2'b00;
      #3;
      checks++;
      if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b want 00", grant); end
      checks++;
      if (m_if.waitrequest !== 2'b11) begin errors++; $display("FAIL rst_mwait: got %b want 11", m_if.waitrequest); end
      checks++;
      if ({s_if.read, s_if.write} !== 2'b00) begin errors++; $display("FAIL rst_strobe: got %b want 00", {s_if.read, s_if.write}); end
      checks++;
      if (s_if.address !== 8'h00) begin errors++; $display("FAIL rst_addr: got %h want 00", s_if.address); end
      m_if.read = 2'b00;
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_single_write();
      do_reset(2'b00);
      m_if.write = 2'b10;
      tick();
      checks++;
      if (grant !== 2'b10) begin errors++; $display("FAIL wr_grant: got %b want 10", grant); end
      checks++;
      if (s_if.write[0] !== 1'b1 || s_if.read[0] !== 1'b0) begin errors++; $display("FAIL wr_strobe: got w=%b r=%b want w=1 r=0", s_if.write, s_if.read); end
      checks++;
      if (s_if.address !== 8'h3C || s_if.writedata !== 32'hDEADBEEF) begin
         errors++; $display("FAIL wr_fwd: got %h/%h want 3c/deadbeef", s_if.address, s_if.writedata);
      end
      tick();
      checks++;
      if (m_if.waitrequest !== 2'b01) begin errors++; $display("FAIL wr_mwait: got %b want 01", m_if.waitrequest); end
      tick();
      checks++;
      if (grant !== 2'b00) begin errors++; $display("FAIL wr_release: got %b want 00", grant); end
      m_if.write = 2'b00;
   endtask

   task automatic test_two_reads();
      do_reset(2'b00);
      m_if.read = 2'b11;
      tick();
      checks++;
      if (grant !== 2'b01 || s_if.read[0] !== 1'b1 || s_if.address !== 8'h10) begin
         errors++; $display("FAIL rd0_grant: got g=%b r=%b a=%h want 01/1/10", grant, s_if.read, s_if.address);
      end
      checks++;
      if (m_if.waitrequest !== 2'b11) begin errors++; $display("FAIL rd0_wait: got %b want 11", m_if.waitrequest); end
      s_if.readdata = 32'hA5A5A5A5;
      tick();
      checks++;
      if (m_if.waitrequest !== 2'b10 || m_if.readdata !== 32'hA5A5A5A5) begin
         errors++; $display("FAIL rd0_data: got w=%b d=%h want 10/a5a5a5a5", m_if.waitrequest, m_if.readdata);
      end
      tick();
      m_if.read = 2'b10;
      checks++;
      if (grant !== 2'b00 || m_if.waitrequest !== 2'b11) begin
         errors++; $display("FAIL rd0_done: got g=%b w=%b want 00/11", grant, m_if.waitrequest);
      end
      tick();
      checks++;
      if (grant !== 2'b10 || s_if.address !== 8'h3C) begin errors++; $display("FAIL rd1_grant: got g=%b a=%h want 10/3c", grant, s_if.address); end
      s_if.readdata = 32'h5A5A5A5A;
      tick();
      checks++;
      if (m_if.waitrequest !== 2'b01 || m_if.readdata !== 32'h5A5A5A5A) begin
         errors++; $display("FAIL rd1_data: got w=%b d=%h want 01/5a5a5a5a", m_if.waitrequest, m_if.readdata);
      end
      tick();
      m_if.read = 2'b00;
      checks++;
      if (grant !== 2'b00) begin errors++; $display("FAIL rd1_done: got %b want 00", grant); end
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_g [0:3];
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
      do_reset(2'b00);
      m_if.write = 2'b11;
      for (int t = 0; t < 4; t++) begin
         tick();
         checks++;
         if (grant !== exp_g[t]) begin errors++; $display("FAIL b2b_grant%0d: got %b want %b", t, grant, exp_g[t]); end
         tick();
         tick();
         checks++;
         if (grant !== 2'b00) begin errors++; $display("FAIL b2b_idle%0d: got %b want 00", t, grant); end
      end
      m_if.write = 2'b00;
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset(2'b00);
      force_wait = 1'b1;
      m_if.read = 2'b10;
      tick();
      tick();
      checks++;
      if (grant !== 2'b10 || s_if.read[0] !== 1'b1) begin errors++; $display("FAIL mid_busy: got g=%b r=%b want 10/1", grant, s_if.read); end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (grant !== 2'b00 || s_if.read[0] !== 1'b0 || s_if.write[0] !== 1'b0) begin
         errors++; $display("FAIL mid_abort: got g=%b r=%b w=%b want 00/0/0", grant, s_if.read, s_if.write);
      end
      tick();
      reset_n = 1'b1;
      force_wait = 1'b0;
      m_if.read = 2'b11;
      tick();
      checks++;
      if (grant !== 2'b01) begin errors++; $display("FAIL mid_prio: got %b want 01", grant); end
      m_if.read = 2'b00;
      tick();
   endtask

   task automatic test_abandon();
      do_reset(2'b00);
      force_wait = 1'b1;
      m_if.read = 2'b11;
      tick();
      checks++;
      if (grant !== 2'b01) begin errors++; $display("FAIL ab_grant0: got %b want 01", grant); end
      m_if.read = 2'b10;
      tick();
      checks++;
      if (grant !== 2'b00 || s_if.read[0] !== 1'b0) begin errors++; $display("FAIL ab_release: got g=%b r=%b want 00/0", grant, s_if.read); end
      tick();
      checks++;
      if (grant !== 2'b10 || s_if.read[0] !== 1'b1 || s_if.address !== 8'h3C) begin
         errors++; $display("FAIL ab_grant1: got g=%b r=%b a=%h want 10/1/3c", grant, s_if.read, s_if.address);
      end
      force_wait = 1'b0;
      m_if.read = 2'b00;
      tick();
   endtask

   initial begin
      m_if.read = 2'b00;
      m_if.write = 2'b00;
      m_if.address = '0;
      m_if.writedata = '0;
      s_if.readdata = '0;
      test_reset();
      test_single_write();
      test_two_reads();
      test_back_to_back();
      test_reset_mid();
      test_abandon();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
